// File: rtl/sudoku_pkg.sv
// rtl/sudoku_pkg.sv - shared constants, FSM encoding and cursor helper for the Sudoku input path
package sudoku_pkg;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_X     = 8;
    localparam int BTN_Y     = 9;
    localparam int BTN_Z     = 10;
    localparam int BTN_MODE  = 11;

    localparam int         GRID_N    = 9;
    localparam logic [3:0] DIGIT_MIN = 4'd1;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_PAUSED = 2'd2
    } state_e;

    // Opposing steps in the same cycle cancel; both ends of the axis wrap.
    function automatic logic [3:0] coord_step(input logic [3:0] v, input logic inc,
                                              input logic dec, input logic [3:0] last);
        logic [3:0] r;
        r = v;
        if (inc && !dec) r = (v == last) ? 4'd0 : v + 4'd1;
        if (dec && !inc) r = (v == 4'd0) ? last : v - 4'd1;
        return r;
    endfunction

endpackage

// File: rtl/button_repeat.sv
// rtl/button_repeat.sv - per-direction step generator: immediate step on press, then hold/auto-repeat steps
module button_repeat #(
    parameter int HOLD_DELAY    = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic press_i,
    input  logic held_i,
    output logic step_o
);

    localparam int              CW       = $clog2(HOLD_DELAY + 1);
    localparam logic [CW-1:0]   HOLD_C   = CW'(HOLD_DELAY);
    // Reloading here makes the counter reach HOLD_C again exactly REPEAT_PERIOD cycles later.
    localparam logic [CW-1:0]   RELOAD_C = CW'(HOLD_DELAY - REPEAT_PERIOD + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = '0;
        step_o = 1'b0;
        if (press_i) begin
            cnt_d  = CW'(1);
            step_o = 1'b1;
        end else if (held_i && cnt_q != '0) begin
            if (cnt_q == HOLD_C) begin
                cnt_d  = RELOAD_C;
                step_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sudoku_input_controller.sv
// rtl/sudoku_input_controller.sv - maps debounced buttons to cursor, digit, write/clear and pause actions
module sudoku_input_controller
    import sudoku_pkg::*;
#(
    parameter int HOLD_DELAY    = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int GRID          = GRID_N
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] buttons,
    input  logic        game_lock,
    input  logic        cell_fixed,
    input  logic        wr_ack,
    output logic [3:0]  cur_row,
    output logic [3:0]  cur_col,
    output logic [3:0]  digit,
    output logic        wr_req,
    output logic [3:0]  wr_row,
    output logic [3:0]  wr_col,
    output logic [3:0]  wr_value,
    output logic        block_controller,
    output logic        paused,
    output logic        err_fixed
);

    localparam logic [3:0] LAST = 4'(GRID - 1);
    localparam logic [3:0] MID  = 4'(GRID / 2);

    state_e      state_q, state_d;
    logic [11:0] prev_q;
    logic [3:0]  row_q, row_d, col_q, col_d, digit_q, digit_d;
    logic [3:0]  wr_row_q, wr_row_d, wr_col_q, wr_col_d, wr_val_q, wr_val_d;
    logic        wr_req_q, wr_req_d, paused_q, paused_d, err_q, err_d;
    logic [11:0] press;
    logic [3:0]  step;
    logic        active;

    assign press  = buttons & ~prev_q;
    assign active = (state_q == ST_IDLE) && !game_lock;

    // Counters only run while events are accepted; any other state clears them.
    for (genvar d = 0; d < 4; d++) begin : g_rep
        button_repeat #(
            .HOLD_DELAY   (HOLD_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_rep (
            .clk    (clk),
            .rst_n  (reset),
            .press_i(press[d] & active),
            .held_i (buttons[d] & active),
            .step_o (step[d])
        );
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        digit_d  = digit_q;
        wr_row_d = wr_row_q;
        wr_col_d = wr_col_q;
        wr_val_d = wr_val_q;
        wr_req_d = wr_req_q;
        paused_d = paused_q;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!game_lock) begin
                    if (press[BTN_START]) begin
                        paused_d = 1'b1;
                        state_d  = ST_PAUSED;
                    end else if (press[BTN_C] || press[BTN_X]) begin
                        if (cell_fixed) begin
                            err_d = 1'b1;
                        end else begin
                            wr_row_d = row_q;
                            wr_col_d = col_q;
                            wr_val_d = press[BTN_C] ? digit_q : 4'd0;
                            wr_req_d = 1'b1;
                            state_d  = ST_WRITE;
                        end
                    end else if (|step) begin
                        row_d = coord_step(row_q, step[BTN_DOWN], step[BTN_UP], LAST);
                        col_d = coord_step(col_q, step[BTN_RIGHT], step[BTN_LEFT], LAST);
                    end else if (press[BTN_A] && !press[BTN_B]) begin
                        digit_d = (digit_q == DIGIT_MAX) ? DIGIT_MIN : digit_q + 4'd1;
                    end else if (press[BTN_B] && !press[BTN_A]) begin
                        digit_d = (digit_q == DIGIT_MIN) ? DIGIT_MAX : digit_q - 4'd1;
                    end
                end
            end
            ST_WRITE: begin
                if (wr_ack) begin
                    wr_req_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_PAUSED: begin
                if (!game_lock && press[BTN_START]) begin
                    paused_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            prev_q   <= '0;
            row_q    <= MID;
            col_q    <= MID;
            digit_q  <= DIGIT_MIN;
            wr_row_q <= '0;
            wr_col_q <= '0;
            wr_val_q <= '0;
            wr_req_q <= 1'b0;
            paused_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= buttons;
            row_q    <= row_d;
            col_q    <= col_d;
            digit_q  <= digit_d;
            wr_row_q <= wr_row_d;
            wr_col_q <= wr_col_d;
            wr_val_q <= wr_val_d;
            wr_req_q <= wr_req_d;
            paused_q <= paused_d;
            err_q    <= err_d;
        end
    end

    assign cur_row          = row_q;
    assign cur_col          = col_q;
    assign digit            = digit_q;
    assign wr_req           = wr_req_q;
    assign wr_row           = wr_row_q;
    assign wr_col           = wr_col_q;
    assign wr_value         = wr_val_q;
    assign block_controller = (state_q == ST_WRITE);
    assign paused           = paused_q;
    assign err_fixed        = err_q;

endmodule

// File: tb/tb_sudoku_input_controller.sv
// tb/tb_sudoku_input_controller.sv - directed and randomized checks against a behavioural game-input model
module tb_sudoku_input_controller;

    localparam int HOLD = 10;
    localparam int PER  = 4;

    localparam logic [11:0] M_UP    = 12'h001;
    localparam logic [11:0] M_RIGHT = 12'h008;
    localparam logic [11:0] M_A     = 12'h010;
    localparam logic [11:0] M_B     = 12'h020;
    localparam logic [11:0] M_C     = 12'h040;
    localparam logic [11:0] M_START = 12'h080;
    localparam logic [11:0] M_X     = 12'h100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] buttons = '0;
    logic        game_lock = 1'b0, cell_fixed = 1'b0, wr_ack = 1'b0;
    logic [3:0]  cur_row, cur_col, digit, wr_row, wr_col, wr_value;
    logic        wr_req, block_controller, paused, err_fixed;

    int total = 0;
    int bad   = 0;

    // Behavioural model: mode 0 = accepting, 1 = waiting for board write, 2 = paused.
    int          m_row, m_col, m_digit, m_mode, m_wrow, m_wcol, m_wval;
    bit          m_req, m_paused, m_err;
    logic [11:0] m_prev;
    int          m_age [4];

    sudoku_input_controller #(
        .HOLD_DELAY   (HOLD),
        .REPEAT_PERIOD(PER),
        .GRID         (9)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .buttons         (buttons),
        .game_lock       (game_lock),
        .cell_fixed      (cell_fixed),
        .wr_ack          (wr_ack),
        .cur_row         (cur_row),
        .cur_col         (cur_col),
        .digit           (digit),
        .wr_req          (wr_req),
        .wr_row          (wr_row),
        .wr_col          (wr_col),
        .wr_value        (wr_value),
        .block_controller(block_controller),
        .paused          (paused),
        .err_fixed       (err_fixed)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_row = 4; m_col = 4; m_digit = 1; m_mode = 0;
        m_wrow = 0; m_wcol = 0; m_wval = 0;
        m_req = 0; m_paused = 0; m_err = 0; m_prev = '0;
        for (int d = 0; d < 4; d++) m_age[d] = -1;
    endtask

    task automatic model_clock(input logic [11:0] b, input logic lk, input logic fx, input logic ak);
        logic [11:0] pr;
        bit [3:0]    st;
        bit          act;
        pr  = b & ~m_prev;
        act = (m_mode == 0) && !lk;
        for (int d = 0; d < 4; d++) begin
            if (act && pr[d]) begin
                m_age[d] = 0;
                st[d] = 1;
            end else if (act && b[d] && m_age[d] >= 0) begin
                m_age[d]++;
                st[d] = (m_age[d] == HOLD) || (m_age[d] > HOLD && (m_age[d] - HOLD) % PER == 0);
            end else begin
                m_age[d] = -1;
                st[d] = 0;
            end
        end
        m_err  = 0;
        m_prev = b;
        case (m_mode)
            0: if (act) begin
                if (pr[7]) begin
                    m_paused = 1; m_mode = 2;
                end else if (pr[6] || pr[8]) begin
                    if (fx) m_err = 1;
                    else begin
                        m_wrow = m_row; m_wcol = m_col;
                        m_wval = pr[6] ? m_digit : 0;
                        m_req = 1; m_mode = 1;
                    end
                end else if (st != 0) begin
                    if (st[1] && !st[0]) m_row = (m_row + 1) % 9;
                    if (st[0] && !st[1]) m_row = (m_row + 8) % 9;
                    if (st[3] && !st[2]) m_col = (m_col + 1) % 9;
                    if (st[2] && !st[3]) m_col = (m_col + 8) % 9;
                end else if (pr[4] && !pr[5]) m_digit = m_digit % 9 + 1;
                else if (pr[5] && !pr[4]) m_digit = (m_digit + 7) % 9 + 1;
            end
            1: if (ak) begin m_req = 0; m_mode = 0; end
            default: if (!lk && pr[7]) begin m_paused = 0; m_mode = 0; end
        endcase
    endtask

    task automatic tick(input logic [11:0] b, input logic lk, input logic fx, input logic ak);
        buttons = b; game_lock = lk; cell_fixed = fx; wr_ack = ak;
        model_clock(b, lk, fx, ak);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        buttons = '0; game_lock = 0; cell_fixed = 0; wr_ack = 0;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({cur_row, cur_col, digit} !== {4'd4, 4'd4, 4'd1}) begin
            bad++; $display("FAIL reset_cursor: got %h want 441", {cur_row, cur_col, digit});
        end
        total++;
        if ({wr_req, wr_row, wr_col, wr_value, block_controller, paused, err_fixed} !== 16'h0) begin
            bad++; $display("FAIL reset_ctrl: got %h want 0000",
                            {wr_req, wr_row, wr_col, wr_value, block_controller, paused, err_fixed});
        end
    endtask

    task automatic test_right_press();
        tick(M_RIGHT, 0, 0, 0);
        total++;
        if (cur_col !== 4'd5 || cur_row !== 4'd4) begin
            bad++; $display("FAIL right_press: got row=%0d col=%0d want row=4 col=5", cur_row, cur_col);
        end
        tick('0, 0, 0, 0);
    endtask

    task automatic test_up_repeat();
        int n, exp_row;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            tick(M_UP, 0, 0, 0);
            tick('0, 0, 0, 0);
        end
        total++;
        if (cur_row !== 4'd0) begin
            bad++; $display("FAIL up_to_zero: got %0d want 0", cur_row);
        end
        for (int i = 1; i <= 30; i++) begin
            tick(M_UP, 0, 0, 0);
            n = 1 + ((i >= HOLD + 1) ? (i - HOLD - 1) / PER + 1 : 0);
            exp_row = (36 - n) % 9;
            total++;
            if (cur_row !== 4'(exp_row)) begin
                bad++; $display("FAIL up_repeat t=%0d: got %0d want %0d", i, cur_row, exp_row);
            end
        end
        tick('0, 0, 0, 0);
    endtask

    task automatic test_digit();
        apply_reset();
        for (int k = 1; k <= 9; k++) begin
            tick(M_A, 0, 0, 0);
            total++;
            if (digit !== 4'(k % 9 + 1)) begin
                bad++; $display("FAIL digit_inc k=%0d: got %0d want %0d", k, digit, k % 9 + 1);
            end
            tick('0, 0, 0, 0);
        end
        tick(M_B, 0, 0, 0);
        total++;
        if (digit !== 4'd9) begin
            bad++; $display("FAIL digit_dec_wrap: got %0d want 9", digit);
        end
        tick('0, 0, 0, 0);
    endtask

    task automatic test_write();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            tick(M_B, 0, 0, 0);
            tick('0, 0, 0, 0);
        end
        tick(M_C, 0, 0, 0);
        total++;
        if ({wr_req, block_controller, wr_row, wr_col, wr_value} !== {1'b1, 1'b1, 4'd4, 4'd4, 4'd7}) begin
            bad++; $display("FAIL write_req: got req=%0d blk=%0d r=%0d c=%0d v=%0d want 1 1 4 4 7",
                            wr_req, block_controller, wr_row, wr_col, wr_value);
        end
        for (int k = 0; k < 3; k++) tick(M_RIGHT, 0, 0, 0);
        total++;
        if (wr_req !== 1'b1 || block_controller !== 1'b1 || cur_col !== 4'd4) begin
            bad++; $display("FAIL write_wait: got req=%0d blk=%0d col=%0d want 1 1 4",
                            wr_req, block_controller, cur_col);
        end
        tick(M_RIGHT, 0, 0, 1);
        total++;
        if (wr_req !== 1'b0 || block_controller !== 1'b0) begin
            bad++; $display("FAIL write_ack: got req=%0d blk=%0d want 0 0", wr_req, block_controller);
        end
        tick(M_RIGHT, 0, 0, 0);
        total++;
        if (cur_col !== 4'd4) begin
            bad++; $display("FAIL no_late_edge: got col=%0d want 4", cur_col);
        end
        tick('0, 0, 0, 0);
    endtask

    task automatic test_fixed_cell();
        apply_reset();
        tick(M_X, 0, 1, 0);
        total++;
        if ({wr_req, block_controller, err_fixed} !== 3'b001) begin
            bad++; $display("FAIL fixed_err: got %b want 001", {wr_req, block_controller, err_fixed});
        end
        tick('0, 0, 1, 0);
        total++;
        if ({wr_req, err_fixed} !== 2'b00) begin
            bad++; $display("FAIL fixed_err_pulse: got %b want 00", {wr_req, err_fixed});
        end
    endtask

    task automatic test_pause();
        apply_reset();
        tick(M_START, 0, 0, 0);
        total++;
        if (paused !== 1'b1) begin
            bad++; $display("FAIL pause_enter: got %0d want 1", paused);
        end
        tick('0, 0, 0, 0);
        tick(M_RIGHT, 0, 0, 0);
        tick('0, 0, 0, 0);
        tick(M_C, 0, 0, 0);
        total++;
        if ({cur_col, wr_req, paused} !== {4'd4, 1'b0, 1'b1}) begin
            bad++; $display("FAIL pause_ignore: got col=%0d req=%0d paused=%0d want 4 0 1",
                            cur_col, wr_req, paused);
        end
        tick('0, 0, 0, 0);
        tick(M_START, 0, 0, 0);
        total++;
        if (paused !== 1'b0) begin
            bad++; $display("FAIL pause_exit: got %0d want 0", paused);
        end
        tick('0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_write();
        apply_reset();
        tick(M_RIGHT, 0, 0, 0);
        tick('0, 0, 0, 0);
        tick(M_C, 0, 0, 0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        total++;
        if ({wr_req, block_controller, cur_row, cur_col} !== {1'b0, 1'b0, 4'd4, 4'd4}) begin
            bad++; $display("FAIL reset_mid_write: got req=%0d blk=%0d r=%0d c=%0d want 0 0 4 4",
                            wr_req, block_controller, cur_row, cur_col);
        end
        buttons = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [11:0] b;
        logic        lk;
        logic [33:0] got, exp;
        apply_reset();
        b  = '0;
        lk = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) b = 12'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 49) == 0) lk = ~lk;
            tick(b, lk, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
            got = {cur_row, cur_col, digit, wr_req, wr_row, wr_col, wr_value, block_controller, paused, err_fixed};
            exp = {4'(m_row), 4'(m_col), 4'(m_digit), m_req, 4'(m_wrow), 4'(m_wcol), 4'(m_wval),
                   (m_mode == 1), m_paused, m_err};
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL random cyc=%0d: got %h want %h", i, got, exp);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_right_press();
        test_up_repeat();
        test_digit();
        test_write();
        test_fixed_cell();
        test_pause();
        test_reset_mid_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
